// File: rtl/simddr_pkg.sv
// Shared types and helpers for the simulation DDR model (simddr_mc).
// Holds the controller state encoding, the default latency counter width
// and the burst alignment helper.
package simddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } simddr_state_e;

  // Default response latency.
  // The top widens its counter beyond CNT_W if its LATENCY parameter needs more bits.
  localparam int SIMDDR_LATENCY_DEF = 4;
  localparam int CNT_W = $clog2(SIMDDR_LATENCY_DEF + 8);

  // Align a word index down to the start of its burst.
  // burst_len must be a power of two.
  function automatic logic [31:0] burst_base(input logic [31:0] idx,
                                             input int unsigned burst_len);
    return idx & ~(burst_len - 32'd1);
  endfunction

endpackage

// File: rtl/simddr_rr_arb.sv
// Round-robin arbiter for simddr_mc. Purely combinational.
// Ports:
//   req       in   NUM_CH  request vector
//   ptr       in   IDX_W   channel with highest priority this cycle
//   grant     out  NUM_CH  one-hot grant, zero when no request
//   grant_idx out  IDX_W   index of the granted channel (0 when none)
module simddr_rr_arb #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic             found;
  int               c;
  logic [IDX_W-1:0] ci;

  // Walk the channels starting at ptr, wrapping once; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    ci        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      ci = IDX_W'(c);
      if (!found && req[ci]) begin
        found     = 1'b1;
        grant[ci] = 1'b1;
        grant_idx = ci;
      end
    end
  end

endmodule

// File: rtl/simddr_mc.sv
// Multi-channel simulation DDR model.
// NUM_CH requesters share one word-indexed memory through a round-robin
// arbiter. It serves masked single-word reads/writes and aligned burst reads,
// and responds a programmable number of cycles after acceptance.
// Optional feature macro: SIMDDR_RANDLAT_EN
//   When defined, each request's latency is LATENCY + lfsr[2:0], drawn from
//   a 16-bit Fibonacci LFSR.
// Ports:
//   clock, reset  clock; synchronous active-high reset
//   req_valid     in   NUM_CH                   request valid per channel
//   req_ready     out  NUM_CH                   accept (one-hot or zero, IDLE only)
//   req_write     in   NUM_CH                   1 = write, 0 = read
//   req_burst     in   NUM_CH                   burst read (ignored for writes)
//   req_index     in   NUM_CH*ADDR_W            word index per channel
//   req_wmask     in   NUM_CH*DATA_W            bit-granular write mask
//   req_wdata     in   NUM_CH*DATA_W            write data
//   resp_valid    out  NUM_CH                   one-cycle completion pulse
//   resp_data     out  NUM_CH*DATA_W*BURST_LEN  read line per channel, held until next response
//   busy          out  1                        high whenever not IDLE
module simddr_mc
  import simddr_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          ADDR_W    = 19,
  parameter int          DATA_W    = 64,
  parameter int          BURST_LEN = 8,
  parameter int          LATENCY   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   req_valid,
  output logic [NUM_CH-1:0]                   req_ready,
  input  logic [NUM_CH-1:0]                   req_write,
  input  logic [NUM_CH-1:0]                   req_burst,
  input  logic [NUM_CH*ADDR_W-1:0]            req_index,
  input  logic [NUM_CH*DATA_W-1:0]            req_wmask,
  input  logic [NUM_CH*DATA_W-1:0]            req_wdata,
  output logic [NUM_CH-1:0]                   resp_valid,
  output logic [NUM_CH*DATA_W*BURST_LEN-1:0]  resp_data,
  output logic                                busy
);

  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW        = ($clog2(LATENCY + 8) > CNT_W) ? $clog2(LATENCY + 8) : CNT_W;
  localparam int LINE_W    = DATA_W * BURST_LEN;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  if (LFSR_SEED == 16'd0) begin : g_bad_seed
    $error("simddr_mc: LFSR_SEED must be non-zero");
  end
  if ((BURST_LEN < 2) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_burst
    $error("simddr_mc: BURST_LEN must be a power of two >= 2");
  end

  simddr_state_e           state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [NUM_CH-1:0]       resp_valid_q, resp_valid_d;
  logic [NUM_CH*LINE_W-1:0] resp_data_q, resp_data_d;

  logic [IDX_W-1:0]        lat_ch_q, lat_ch_d;
  logic                    lat_write_q, lat_write_d;
  logic                    lat_burst_q, lat_burst_d;
  logic [ADDR_W-1:0]       lat_index_q, lat_index_d;
  logic [DATA_W-1:0]       lat_wmask_q, lat_wmask_d;
  logic [DATA_W-1:0]       lat_wdata_q, lat_wdata_d;

  logic [DATA_W-1:0]       mem [0:MEM_DEPTH-1];
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wval;
  logic [ADDR_W-1:0]       rd_base;
  logic [LINE_W-1:0]       rd_line;

  logic [NUM_CH-1:0]       gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic [CW-1:0]           lat_l;

  simddr_rr_arb #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

`ifdef SIMDDR_RANDLAT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lat_l = CW'(LATENCY) + CW'(lfsr_q[2:0]);
`else
  assign lat_l = CW'(LATENCY);
`endif

  // Ready is withheld during reset so nothing looks accepted while the FSM is being cleared.
  assign req_ready  = ((state_q == IDLE) && !reset) ? gnt : '0;
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    lat_ch_d     = lat_ch_q;
    lat_write_d  = lat_write_q;
    lat_burst_d  = lat_burst_q;
    lat_index_d  = lat_index_q;
    lat_wmask_d  = lat_wmask_q;
    lat_wdata_d  = lat_wdata_q;
    mem_we       = 1'b0;
    mem_wval     = '0;
    rd_base      = '0;
    rd_line      = '0;
`ifdef SIMDDR_RANDLAT_EN
    lfsr_d       = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = BUSY;
          cnt_d       = lat_l;
          lat_ch_d    = gnt_idx;
          lat_write_d = req_write[gnt_idx];
          lat_burst_d = req_burst[gnt_idx];
          lat_index_d = req_index[int'(gnt_idx)*ADDR_W +: ADDR_W];
          lat_wmask_d = req_wmask[int'(gnt_idx)*DATA_W +: DATA_W];
          lat_wdata_d = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          ptr_d       = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
`ifdef SIMDDR_RANDLAT_EN
          lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
        end
      end
      BUSY: begin
        // Loaded with L and leaving on 1 gives exactly L cycles here.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: begin
        state_d                = IDLE;
        resp_valid_d[lat_ch_q] = 1'b1;
        if (lat_write_q) begin
          mem_we   = 1'b1;
          mem_wval = (mem[lat_index_q] & ~lat_wmask_q) | (lat_wdata_q & lat_wmask_q);
        end else begin
          rd_base = lat_burst_q ? ADDR_W'(burst_base(32'(lat_index_q), BURST_LEN)) : lat_index_q;
          for (int i = 0; i < BURST_LEN; i++) begin
            if (lat_burst_q || (i == 0)) begin
              rd_line[i*DATA_W +: DATA_W] = mem[rd_base + ADDR_W'(i)];
            end
          end
          resp_data_d[int'(lat_ch_q)*LINE_W +: LINE_W] = rd_line;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
`ifdef SIMDDR_RANDLAT_EN
      lfsr_q       <= LFSR_SEED;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef SIMDDR_RANDLAT_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  // Latched request fields: only meaningful while BUSY/RESP, so no reset.
  always_ff @(posedge clock) begin
    lat_ch_q    <= lat_ch_d;
    lat_write_q <= lat_write_d;
    lat_burst_q <= lat_burst_d;
    lat_index_q <= lat_index_d;
    lat_wmask_q <= lat_wmask_d;
    lat_wdata_q <= lat_wdata_d;
  end

  // Memory survives reset; gating on reset drops a write caught in RESP.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[lat_index_q] <= mem_wval;
  end

  always_ff @(posedge clock) begin
    if (!reset && (state_q == RESP) && lat_write_q && lat_burst_q)
      $error("simddr_mc: burst flag set on write to index %0h, executed as single write",
             lat_index_q);
  end

endmodule

// File: tb/tb_simddr_mc.sv
// Testbench for simddr_mc (NUM_CH=2). Directed scenarios followed by randomized
// traffic, all checked against a behavioural memory/arbitration model.
module tb_simddr_mc;

  localparam int          NUM_CH    = 2;
  localparam int          ADDR_W    = 19;
  localparam int          DATA_W    = 64;
  localparam int          BURST_LEN = 8;
  localparam int          LATENCY   = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          LINE_W    = DATA_W * BURST_LEN;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [NUM_CH-1:0]          req_valid, req_ready, req_write, req_burst, resp_valid;
  logic [NUM_CH*ADDR_W-1:0]   req_index;
  logic [NUM_CH*DATA_W-1:0]   req_wmask, req_wdata;
  logic [NUM_CH*LINE_W-1:0]   resp_data;
  logic                       busy;

  simddr_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BURST_LEN(BURST_LEN), .LATENCY(LATENCY), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_burst(req_burst), .req_index(req_index), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:31];
  logic [LINE_W-1:0] last_resp [0:NUM_CH-1];
  int                ptr_m;
`ifdef SIMDDR_RANDLAT_EN
  logic [15:0]       lfsr_m;
`endif

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept-to-response gap for the next accepted request.
  function automatic int model_gap();
`ifdef SIMDDR_RANDLAT_EN
    int g;
    g = LATENCY + int'(lfsr_m[2:0]) + 1;
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    return g;
`else
    return LATENCY + 1;
`endif
  endfunction

  function automatic logic [LINE_W-1:0] exp_read(input int idx, input bit burst);
    logic [LINE_W-1:0] l;
    int base;
    l = '0;
    if (burst) begin
      base = idx - (idx % BURST_LEN);
      for (int i = 0; i < BURST_LEN; i++) l[i*DATA_W +: DATA_W] = ref_mem[base + i];
    end else begin
      l[DATA_W-1:0] = ref_mem[idx];
    end
    return l;
  endfunction

  task automatic model_reset();
    ptr_m = 0;
    for (int c = 0; c < NUM_CH; c++) last_resp[c] = '0;
`ifdef SIMDDR_RANDLAT_EN
    lfsr_m = LFSR_SEED;
`endif
  endtask

  // One complete transaction on channel c with the other channel idle.
  // Called at a negedge; returns at a negedge.
  task automatic do_req(input logic c, input bit wr, input bit bu, input int idx,
                        input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] d);
    int n, acc, gap;
    logic [LINE_W-1:0] exp;
    logic o;
    o = ~c;
    req_valid[c] = 1'b1;
    req_write[c] = wr;
    req_burst[c] = bu;
    req_index[int'(c)*ADDR_W +: ADDR_W] = ADDR_W'(idx);
    req_wmask[int'(c)*DATA_W +: DATA_W] = m;
    req_wdata[int'(c)*DATA_W +: DATA_W] = d;
    #1;
    n = 0;
    while (req_ready[c] !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    chk("ready", LINE_W'(req_ready), LINE_W'(2'b01 << c));
    @(posedge clock); #1;
    acc = cyc;
    gap = model_gap();
    ptr_m = (int'(c) + 1) % NUM_CH;
    @(negedge clock);
    req_valid[c] = 1'b0;
    req_write[c] = 1'b0;
    req_burst[c] = 1'b0;
    n = 0;
    while (resp_valid[c] !== 1'b1 && n < 40) begin
      @(negedge clock); n++;
    end
    chk("resp_gap", LINE_W'(cyc - acc), LINE_W'(gap));
    chk("resp_onehot", LINE_W'(resp_valid), LINE_W'(2'b01 << c));
    if (wr) begin
      ref_mem[idx] = (ref_mem[idx] & ~m) | (d & m);
      exp = last_resp[c];
    end else begin
      exp = exp_read(idx, bu);
      last_resp[c] = exp;
    end
    chk(wr ? "wr_data_held" : "rd_data", resp_data[int'(c)*LINE_W +: LINE_W], exp);
    chk("other_held", resp_data[int'(o)*LINE_W +: LINE_W], last_resp[o]);
    @(negedge clock);
    chk("resp_pulse_end", LINE_W'(resp_valid), '0);
  endtask

  int          q_ch[$], q_acc[$], q_gap[$];
  int          grants, pc, pa, pg;
  logic        gc;
  logic [DATA_W-1:0] w, m;

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    model_reset();
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_burst = '0;
    req_index = '0; req_wmask = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", LINE_W'(busy), '0);
    chk("rst_resp_valid", LINE_W'(resp_valid), '0);
    chk("rst_req_ready", LINE_W'(req_ready), '0);
    chk("rst_resp_data0", resp_data[LINE_W-1:0], '0);
    chk("rst_resp_data1", resp_data[2*LINE_W-1:LINE_W], '0);
    reset = 1'b0;
    @(negedge clock);

    // Full write then single read of idx 5.
    do_req(1'b0, 1'b1, 1'b0, 5, '1, 64'h1122_3344_5566_7788);
    do_req(1'b0, 1'b0, 1'b0, 5, '0, '0);
    chk("rd5_word0", resp_data[DATA_W-1:0], LINE_W'(64'h1122_3344_5566_7788));
    chk("rd5_upper", resp_data[LINE_W-1:DATA_W], '0);

    // Partial mask, then a no-op write with wmask = 0.
    do_req(1'b1, 1'b1, 1'b0, 5, '1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 1'b1, 1'b0, 5, 64'h0000_0000_FFFF_0000, '0);
    do_req(1'b1, 1'b1, 1'b0, 5, '0, 64'h1234_5678_9ABC_DEF0);
    do_req(1'b1, 1'b0, 1'b0, 5, '0, '0);
    chk("partial_mask", resp_data[LINE_W +: DATA_W], LINE_W'(64'hFFFF_FFFF_0000_FFFF));

    // Burst read from a mid-burst index.
    for (int i = 16; i < 24; i++) do_req(1'b0, 1'b1, 1'b0, i, '1, 64'(i));
    do_req(1'b1, 1'b0, 1'b1, 21, '0, '0);
    for (int i = 0; i < BURST_LEN; i++)
      chk("burst_word", resp_data[LINE_W + i*DATA_W +: DATA_W], LINE_W'(16 + i));

    // Both channels requesting continuously: rotating grants.
    req_write = '0;
    req_burst = 2'b10;
    req_index[0 +: ADDR_W] = ADDR_W'(5);
    req_index[ADDR_W +: ADDR_W] = ADDR_W'(18);
    req_valid = 2'b11;
    grants = 0;
    for (int k = 0; k < 120 && !(grants >= 4 && q_ch.size() == 0); k++) begin
      if (grants >= 4) req_valid = '0;
      #1;
      if (resp_valid != '0) begin
        if (q_ch.size() == 0) begin
          chk("arb_spurious_resp", LINE_W'(resp_valid), '0);
        end else begin
          pc = q_ch.pop_front(); pa = q_acc.pop_front(); pg = q_gap.pop_front();
          chk("arb_resp_onehot", LINE_W'(resp_valid), LINE_W'(2'b01 << pc));
          chk("arb_resp_gap", LINE_W'(cyc - pa), LINE_W'(pg));
          last_resp[pc] = exp_read(pc == 0 ? 5 : 18, pc == 1);
          chk("arb_resp_data", resp_data[pc*LINE_W +: LINE_W], last_resp[pc]);
        end
      end
      if (req_ready != '0) begin
        chk("arb_grant", LINE_W'(req_ready), LINE_W'(2'b01 << ptr_m));
        gc = req_ready[1];
        q_ch.push_back(int'(gc));
        q_acc.push_back(cyc + 1);
        q_gap.push_back(model_gap());
        ptr_m = (int'(gc) + 1) % NUM_CH;
        grants++;
      end
      @(negedge clock);
    end
    req_valid = '0; req_burst = '0;
    chk("arb_grant_count", LINE_W'(grants), LINE_W'(4));
    chk("arb_drained", LINE_W'(q_ch.size()), '0);

    // Reset during BUSY drops a pending write.
    do_req(1'b0, 1'b1, 1'b0, 9, '1, 64'hA5A5_0F0F_5A5A_F0F0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_index[0 +: ADDR_W] = ADDR_W'(9);
    req_wmask[0 +: DATA_W] = '1;
    req_wdata[0 +: DATA_W] = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("rstmid_ready", LINE_W'(req_ready), LINE_W'(2'b01));
    @(negedge clock);
    req_valid = '0; req_write = '0;
    chk("rstmid_busy", LINE_W'(busy), LINE_W'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("rstmid_busy_after", LINE_W'(busy), '0);
    chk("rstmid_no_resp", LINE_W'(resp_valid), '0);
    chk("rstmid_data_clr", resp_data[LINE_W-1:0], '0);
    do_req(1'b0, 1'b0, 1'b0, 9, '0, '0);
    chk("rstmid_mem9", resp_data[DATA_W-1:0], LINE_W'(64'hA5A5_0F0F_5A5A_F0F0));

    // Randomized traffic over indices 0..31 (preloaded first).
    for (int i = 0; i < 32; i++) begin
      w = {$urandom, $urandom};
      do_req(1'($urandom_range(0, 1)), 1'b1, 1'b0, i, '1, w);
    end
    for (int k = 0; k < 40; k++) begin
      w = {$urandom, $urandom};
      m = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_req(1'($urandom_range(0, 1)), 1'b1, 1'b0, int'($urandom_range(0, 31)), m, w);
      else
        do_req(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
